// File: rtl/alu_pkg.sv
// Shared op-class, funct and ALU op-code definitions
// for the issue/ALU slice.
package alu_pkg;

  typedef enum logic [1:0] {
    CLS_ADD   = 2'b00,
    CLS_SUB   = 2'b01,
    CLS_RTYPE = 2'b10,
    CLS_RSVD  = 2'b11
  } op_class_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_NOR     = 4'b1100,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, add/sub with signed
// overflow, signed set-less-than.
module alu
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  alu_op_e           op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] rd,
  output logic              zero,
  output logic              overflow
);

  localparam int M = DWIDTH - 1;

  logic [DWIDTH-1:0] sum;
  logic [DWIDTH-1:0] diff;
  logic              lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    rd       = '0;
    overflow = 1'b0;
    unique case (op)
      ALU_AND: rd = a & b;
      ALU_OR:  rd = a | b;
      ALU_NOR: rd = ~(a | b);
      ALU_SLT: rd = {{M{1'b0}}, lt};
      ALU_ADD: begin
        rd       = sum;
        overflow = (a[M] == b[M]) &&
                   (sum[M] != a[M]);
      end
      ALU_SUB: begin
        rd       = diff;
        overflow = (a[M] != b[M]) &&
                   (diff[M] != a[M]);
      end
      default: rd = '0;
    endcase
    // an illegal op never reports zero
    zero = (op != ALU_ILLEGAL) && (rd == '0);
  end

endmodule

// File: rtl/alu_ctrl.sv
// Decodes op class + funct into the 4-bit ALU op
// and an illegal flag.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic [1:0] op_class,
  input  logic [5:0] funct,
  output alu_op_e    op,
  output logic       illegal
);

  alu_op_e rop;

  always_comb begin
    rop = ALU_ILLEGAL;
    unique case (funct)
      FUNCT_ADD: rop = ALU_ADD;
      FUNCT_SUB: rop = ALU_SUB;
      FUNCT_AND: rop = ALU_AND;
      FUNCT_OR:  rop = ALU_OR;
      FUNCT_NOR: rop = ALU_NOR;
      FUNCT_SLT: rop = ALU_SLT;
      default:   rop = ALU_ILLEGAL;
    endcase
  end

  always_comb begin
    op = ALU_ILLEGAL;
    unique case (1'b1)
      op_class == CLS_ADD:   op = ALU_ADD;
      op_class == CLS_SUB:   op = ALU_SUB;
      op_class == CLS_RTYPE: op = rop;
      default:               op = ALU_ILLEGAL;
    endcase
    illegal = (op == ALU_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue (E) / writeback (W) wrapper around
// alu with valid/ready on both sides.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int TAGW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op_class,
  input  logic [5:0]        in_funct,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_result,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic [TAGW-1:0]   out_tag,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic [15:0]       done_cnt
);

  logic              e_valid;
  alu_op_e           e_op;
  logic [DWIDTH-1:0] e_a;
  logic [DWIDTH-1:0] e_b;
  logic [TAGW-1:0]   e_tag;
  logic              e_illegal;

  alu_op_e           d_op;
  logic              d_illegal;
  logic [DWIDTH-1:0] x_rd;
  logic              x_zero;
  logic              x_ovf;

  logic e_load;
  logic w_load;
  logic deliver;

  assign in_ready = !e_valid || !out_valid ||
                    out_ready;
  assign e_load   = in_valid && in_ready;
  assign w_load   = e_valid &&
                    (!out_valid || out_ready);
  assign deliver  = out_valid && out_ready;

  alu_ctrl u_ctrl (
    .op_class (in_alu_op_class),
    .funct    (in_funct),
    .op       (d_op),
    .illegal  (d_illegal)
  );

  alu #(.DWIDTH(DWIDTH)) u_alu (
    .op       (e_op),
    .a        (e_a),
    .b        (e_b),
    .rd       (x_rd),
    .zero     (x_zero),
    .overflow (x_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid   <= 1'b0;
      e_op      <= ALU_AND;
      e_a       <= '0;
      e_b       <= '0;
      e_tag     <= '0;
      e_illegal <= 1'b0;
    end else if (e_load) begin
      e_valid   <= 1'b1;
      e_op      <= d_op;
      e_a       <= in_a;
      e_b       <= in_b;
      e_tag     <= in_tag;
      e_illegal <= d_illegal;
    end else if (w_load) begin
      e_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (w_load) begin
      out_valid   <= 1'b1;
      out_result  <= x_rd;
      out_zero    <= x_zero;
      out_ovf     <= x_ovf && !e_illegal;
      out_illegal <= e_illegal;
      out_tag     <= e_tag;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // a delivered overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      done_cnt   <= '0;
    end else begin
      if (deliver && out_ovf) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (deliver) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage pipelined issue/writeback wrapper that drives the `alu` block from the decode side. It accepts decoded instruction fields (`alu_op_class`, `funct`) and operands under a valid/ready handshake, and decodes them into the 4-bit ALU op code. It registers the op and operands toward `alu`, then captures `rd`/`zero`/`overflow` into an output register with its own valid/ready handshake. It sits between the register-read stage and the memory/writeback stage of the single-issue datapath.

## Interface
- `DWIDTH`, 32, operand/result width
- `TAGW`, 5, width of the pass-through destination tag
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  issue request
- `in_ready`  out  1  issue slot can accept this cycle
- `in_alu_op_class`  in  2  00 = add (load/store), 01 = sub (branch), 10 = R-type (use `funct`), 11 = reserved
- `in_funct`  in  6  R-type function field
- `in_a`, `in_b`  in  DWIDTH  operands
- `in_tag`  in  TAGW  destination register tag
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_result`  out  DWIDTH  ALU result
- `out_zero`  out  1  ALU zero flag
- `out_ovf`  out  1  signed overflow (add/sub only)
- `out_illegal`  out  1  op class/funct did not decode
- `out_tag`  out  TAGW  tag of this result
- `ovf_sticky`  out  1  set by any delivered result with `out_ovf`=1; cleared by reset or `ovf_clr`
- `ovf_clr`  in  1  clears `ovf_sticky` (set wins if both occur in the same cycle)
- `done_cnt`  out  16  count of results delivered (`out_valid && out_ready`), wraps 0xFFFF→0

## Operation
- Decode: class 00→0010, 01→0110, 11→1111 (illegal).
- Class 10 funct mapping: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 101010→0111; any other funct→1111 (illegal).
- Op 1111 is passed to `alu`; `alu` returns rd=0, zero=0. `out_illegal`=1, `out_ovf`=0.
- Stage E holds e_valid, e_op, e_a, e_b, e_tag, e_illegal; these drive `alu` directly.
- Stage W holds w_valid plus the registered `rd`, `zero`, `overflow`, illegal flag, and tag. The `out_*` ports are the W registers.
- W loads from E when e_valid && (!w_valid || out_ready). W clears when it is drained and E is empty.
- E loads from input when in_valid && in_ready; E clears when it moves to W with no new input.
- in_ready = !e_valid || !w_valid || out_ready (combinational through `out_ready`).
- Reset: e_valid=0, w_valid=0, all out_* data=0, `ovf_sticky`=0, `done_cnt`=0, so `in_ready`=1 one cycle after reset.
- Reset mid-flight discards both stages with no output.

## Timing
- Latency: accept at edge N → `out_valid`=1 after edge N+1 (result visible the cycle after E).
- Throughput: 1 op/cycle while `out_ready`=1.
- Backpressure: if `out_ready`=0 with W and E full, `in_ready`=0. Outputs hold stable until accepted; no data loss or duplication.
- Simultaneous drain and refill of W in one cycle is legal and must not create a bubble.
- `out_*` are held stable while `out_valid && !out_ready`.

## Structure
- Shared package `alu_pkg`:
  - op class codes
  - funct constants (FUNCT_ADD, SUB, AND, OR, NOR, SLT)
  - ALU op codes (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100, ALU_ILLEGAL=1111)
- Sub-module `alu_ctrl`: combinational class+funct → 4-bit op plus illegal bit.
- Instantiate the existing `alu` (DWIDTH passed through) inside stage E.

## Test plan
- Reset with `in_valid`=1 → no acceptance during reset; `out_valid`=0, `done_cnt`=0, `in_ready`=1 on the first post-reset cycle.
- Class 10, funct 100000, a=0x7FFFFFFF, b=1, `out_ready`=1 → two cycles later result 0x80000000, `out_ovf`=1, `zero`=0; `ovf_sticky`=1 the next cycle.
- Class 01, a=5, b=5 → result 0, `zero`=1, `ovf`=0. Class 10, funct 101010, a=0xFFFFFFFF, b=1 → result 1.
- Class 10, funct 000000 → `out_illegal`=1, result 0, `zero`=0, `ovf`=0.
- Back-to-back stream of 8 ops, `out_ready` pattern 1,0,0,1,1,0,1,1… → all 8 results delivered in order with correct tags; `in_ready`=0 only when both stages are full and `out_ready`=0; `done_cnt`=8.
- Preset `done_cnt`=0xFFFF by streaming, deliver one more → 0. `ovf_clr` and an overflowing delivery in the same cycle → `ovf_sticky` stays 1.
